// File: rtl/tt_pin_pkg.sv
// Shared definitions for the TinyTapeout pin-level host.
// Holds the FSM states, the pin bit positions and the default parameter values.
package tt_pin_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    localparam int STROBE_BIT         = 0;
    localparam int LAST_BIT           = 1;
    localparam int RSPV_BIT           = 7;

    localparam int CMD_BYTES_DEF      = 2;
    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam int RST_HOLD_DEF       = 4;

endpackage

// File: rtl/tt_pin_host_if.sv
// Command/response handshake bundle between a requester (master) and tt_pin_host (slave).
interface tt_pin_host_if
    import tt_pin_pkg::*;
#(
    parameter int CMD_BYTES = CMD_BYTES_DEF
);

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [8*CMD_BYTES-1:0] cmd_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [7:0]             rsp_data;
    logic                   rsp_timeout;

    modport master (
        output cmd_valid, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout
    );

endinterface

// File: rtl/tt_pin_timeout.sv
// Loadable 16-bit down-counter; expired_o is high while the count sits at zero.
module tt_pin_timeout (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] value_i,
    output logic        expired_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Load wins over counting; the count parks at zero once reached.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 16'd0);

endmodule

// File: rtl/tt_pin_host.sv
// Drives a TinyTapeout chip's pins: boots it, shifts command bytes out with a strobe,
// then waits (bounded) for the chip to flag a response byte on uio_out[7].
module tt_pin_host
    import tt_pin_pkg::*;
#(
    parameter int CMD_BYTES      = CMD_BYTES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int RST_HOLD       = RST_HOLD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    tt_pin_host_if.slave cmd_if,
    output logic [7:0]   pin_ui,
    output logic [7:0]   pin_uio,
    input  logic [7:0]   pin_uo,
    input  logic [7:0]   pin_uio_out,
    input  logic [7:0]   pin_uio_oe,
    output logic         pin_ena,
    output logic         pin_rst_n
);

    localparam logic [2:0]  LAST_IDX  = 3'(CMD_BYTES - 1);
    localparam logic [15:0] BOOT_LOAD = 16'(RST_HOLD - 1);
    localparam logic [15:0] WAIT_LOAD = 16'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [8*CMD_BYTES-1:0] frame_q, frame_d;
    logic [2:0]             idx_q, idx_d;
    logic                   armed_q, armed_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [7:0]             rsp_data_q, rsp_data_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic [7:0]             pin_ui_q, pin_ui_d;
    logic [7:0]             pin_uio_q, pin_uio_d;
    logic                   pin_on_q, pin_on_d;

    logic                   tmo_load_s;
    logic [15:0]            tmo_value_s;
    logic                   tmo_expired_s;
    logic                   rsp_present_s;
    logic                   unused_s;

    function automatic logic [7:0] frame_byte(input logic [8*CMD_BYTES-1:0] f,
                                              input logic [2:0] k);
        frame_byte = f[8*(CMD_BYTES-1-int'(k)) +: 8];
    endfunction

    assign rsp_present_s = pin_uio_oe[RSPV_BIT] & pin_uio_out[RSPV_BIT];
    assign unused_s      = ^{pin_uio_out[6:0], pin_uio_oe[6:0]};

    tt_pin_timeout u_timeout (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmo_load_s),
        .value_i   (tmo_value_s),
        .expired_o (tmo_expired_s)
    );

    // Next-state logic; the timer is armed on the first BOOT cycle and on WAIT entry.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        idx_d         = idx_q;
        armed_d       = armed_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        tmo_load_s    = 1'b0;
        tmo_value_s   = 16'd0;
        case (state_q)
            ST_BOOT: begin
                if (!armed_q) begin
                    armed_d     = 1'b1;
                    tmo_load_s  = 1'b1;
                    tmo_value_s = BOOT_LOAD;
                end else if (tmo_expired_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BOOT;
                end
            end
            ST_IDLE: begin
                if (cmd_if.cmd_valid && cmd_ready_q) begin
                    frame_d = cmd_if.cmd_data;
                    idx_d   = 3'd0;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_WAIT;
                    tmo_load_s  = 1'b1;
                    tmo_value_s = WAIT_LOAD;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_SETUP;
                end
            end
            ST_WAIT: begin
                // A response seen in the same cycle the timer expires still counts.
                if (rsp_present_s) begin
                    rsp_data_d    = pin_uo;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (tmo_expired_s) begin
                    rsp_data_d    = 8'h00;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && cmd_if.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Output values derived from the next state so every output leaves a flop.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        pin_on_d    = (state_d != ST_BOOT);
        pin_ui_d    = 8'h00;
        pin_uio_d   = 8'h00;
        if ((state_d == ST_SETUP) || (state_d == ST_STROBE)) begin
            pin_ui_d = frame_byte(frame_d, idx_d);
        end else begin
            pin_ui_d = 8'h00;
        end
        if (state_d == ST_STROBE) begin
            pin_uio_d[STROBE_BIT] = 1'b1;
            pin_uio_d[LAST_BIT]   = (idx_d == LAST_IDX);
        end else begin
            pin_uio_d = 8'h00;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            frame_q       <= '0;
            idx_q         <= 3'd0;
            armed_q       <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
            pin_ui_q      <= 8'h00;
            pin_uio_q     <= 8'h00;
            pin_on_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            idx_q         <= idx_d;
            armed_q       <= armed_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            pin_ui_q      <= pin_ui_d;
            pin_uio_q     <= pin_uio_d;
            pin_on_q      <= pin_on_d;
        end
    end

    assign cmd_if.cmd_ready   = cmd_ready_q;
    assign cmd_if.rsp_valid   = rsp_valid_q;
    assign cmd_if.rsp_data    = rsp_data_q;
    assign cmd_if.rsp_timeout = rsp_timeout_q;
    assign pin_ui             = pin_ui_q;
    assign pin_uio            = pin_uio_q;
    assign pin_ena            = pin_on_q;
    assign pin_rst_n          = pin_on_q;

endmodule

// File: tb/tb_tt_pin_host.sv
// Directed + randomized bench for tt_pin_host; expectations come from a cycle-level
// model of frame timing and response/timeout outcome.
module tb_tt_pin_host;

    localparam int NB   = 2;
    localparam int FW   = 8 * NB;
    localparam int TMO  = 8;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pin_ui;
    logic [7:0] pin_uio;
    logic [7:0] pin_uo;
    logic [7:0] pin_uio_out;
    logic [7:0] pin_uio_oe;
    logic       pin_ena;
    logic       pin_rst_n;

    int checks = 0;
    int errors = 0;

    tt_pin_host_if #(.CMD_BYTES(NB)) bus ();

    tt_pin_host #(
        .CMD_BYTES      (NB),
        .TIMEOUT_CYCLES (TMO),
        .RST_HOLD       (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_if      (bus),
        .pin_ui      (pin_ui),
        .pin_uio     (pin_uio),
        .pin_uo      (pin_uo),
        .pin_uio_out (pin_uio_out),
        .pin_uio_oe  (pin_uio_oe),
        .pin_ena     (pin_ena),
        .pin_rst_n   (pin_rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check(tag, 32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout, bus.rsp_data,
                        pin_ui, pin_uio, pin_ena, pin_rst_n}), 32'd0);
    endtask

    // Random pin noise that never looks like a valid response.
    task automatic drive_noise();
        logic [7:0] o;
        logic [7:0] e;
        o = 8'($urandom);
        e = 8'($urandom);
        if (o[7] && e[7]) o[7] = 1'b0;
        pin_uo      = 8'($urandom);
        pin_uio_out = o;
        pin_uio_oe  = e;
    endtask

    task automatic boot_check();
        int low;
        bit bad;
        low = 0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (pin_rst_n !== 1'b0) break;
            low++;
            if (pin_ena !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) bad = 1'b1;
        end
        check("boot_low_cycles", 32'(low), 32'(HOLD));
        check("boot_quiet", 32'(bad), 32'd0);
        check("boot_ena", 32'(pin_ena), 32'd1);
        check("boot_rst_n", 32'(pin_rst_n), 32'd1);
        check("boot_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    // d = cycles after the last strobe at which the chip flags a response (0 = never).
    task automatic run_frame(input logic [FW-1:0] f, input int d, input bit gated,
                             input logic [7:0] rbyte, input int hold);
        int         exp_cycle;
        logic [7:0] exp_data;
        logic       exp_tmo;
        logic [7:0] exp_ui;
        logic [7:0] exp_uio;
        logic [FW-1:0] sh;
        if (d >= 1 && d <= TMO && !gated) begin
            exp_cycle = 2*NB + d + 1;
            exp_data  = rbyte;
            exp_tmo   = 1'b0;
        end else begin
            exp_cycle = 2*NB + TMO + 1;
            exp_data  = 8'h00;
            exp_tmo   = 1'b1;
        end
        check("idle_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = f;
        for (int c = 1; c <= exp_cycle; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_data  = FW'($urandom);
            end
            if (c <= 2*NB) begin
                sh      = f << (8 * ((c - 1) / 2));
                exp_ui  = sh[FW-1 -: 8];
                exp_uio = {6'd0, c == 2*NB, c % 2 == 0};
            end else begin
                exp_ui  = 8'h00;
                exp_uio = 8'h00;
            end
            check("pin_ui", 32'(pin_ui), 32'(exp_ui));
            check("pin_uio", 32'(pin_uio), 32'(exp_uio));
            check("busy_ready", 32'(bus.cmd_ready), 32'd0);
            check("rsp_valid_timing", 32'(bus.rsp_valid), 32'(c == exp_cycle));
            drive_noise();
            if (d >= 1 && c == 2*NB + d) begin
                pin_uo         = rbyte;
                pin_uio_out[7] = 1'b1;
                pin_uio_oe[7]  = !gated;
            end
        end
        check("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
        check("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_tmo));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            drive_noise();
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_data", 32'(bus.rsp_data), 32'(exp_data));
            check("hold_timeout", 32'(bus.rsp_timeout), 32'(exp_tmo));
            check("hold_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("consumed_valid", 32'(bus.rsp_valid), 32'd0);
        check("consumed_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        pin_uo        = 8'h00;
        pin_uio_out   = 8'h00;
        pin_uio_oe    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset_values");
        @(negedge clk);
        rst = 1'b0;
        boot_check();

        run_frame(16'hA55A, 3, 1'b0, 8'h3C, 0);
        run_frame(FW'($urandom), 0, 1'b0, 8'($urandom), 0);
        run_frame(FW'($urandom), 2, 1'b1, 8'h77, 0);
        run_frame(FW'($urandom), TMO, 1'b0, 8'hC3, 0);
        run_frame(FW'($urandom), 1, 1'b0, 8'h5E, 10);

        for (int n = 0; n < 6; n++) begin
            run_frame(FW'($urandom), int'($urandom_range(0, TMO + 2)),
                      ($urandom_range(0, 3) == 0), 8'($urandom),
                      int'($urandom_range(0, 3)));
        end

        // Reset in the strobe of the final byte aborts the frame.
        check("abort_idle_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = FW'($urandom);
        for (int c = 1; c <= 2*NB; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.cmd_valid = 1'b0;
        end
        check("abort_strobe", 32'(pin_uio), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outs("abort_immediate");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("abort_held");
        @(negedge clk);
        rst = 1'b0;
        boot_check();
        run_frame(16'h1234, 4, 1'b0, 8'h99, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
